// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA job sequencer.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH = 128;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INV_START = 3'd1,
        INV_WAIT  = 3'd2,
        EXP_START = 3'd3,
        EXP_WAIT  = 3'd4,
        DONE      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/rsa_job_sequencer.sv
// Sequences one RSA job through the inverter and mod-exp phases of the control block.
// Optional per-phase wait timeout enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH          = RSA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [WIDTH-1:0]     job_p,
    input  logic [WIDTH-1:0]     job_q,
    input  logic                 job_mode,
    input  logic [2*WIDTH-1:0]   job_msg,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_msg,
    output logic                 res_timeout,
    output logic [WIDTH-1:0]     ctl_p,
    output logic [WIDTH-1:0]     ctl_q,
    output logic                 ctl_mode,
    output logic [2*WIDTH-1:0]   ctl_msg,
    output logic                 ctl_reset_inverter,
    output logic                 ctl_reset_mod_exp,
    input  logic                 ctl_inverter_finish,
    input  logic                 ctl_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   ctl_msg_out,
    output logic                 busy
);

    localparam int unsigned MSG_W = 2 * WIDTH;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t state, state_next;
    logic       wait_first;
    logic       take_job_c;
    logic       capture_c;
    logic       expire_c;
    logic       timeout_hit_c;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit_c = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every entry to a wait state, counts while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == INV_START || state == EXP_START) begin
            wait_cnt <= '0;
        end else if (state == INV_WAIT || state == EXP_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    always_comb begin
        state_next = state;
        take_job_c = 1'b0;
        capture_c  = 1'b0;
        expire_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (job_valid) begin
                    take_job_c = 1'b1;
                    state_next = INV_START;
                end
            end
            INV_START: state_next = INV_WAIT;
            // First wait cycle ignores finish, which may still be high from the previous job.
            INV_WAIT: begin
                if (!wait_first && ctl_inverter_finish) begin
                    state_next = EXP_START;
                end else if (timeout_hit_c) begin
                    expire_c   = 1'b1;
                    state_next = DONE;
                end
            end
            EXP_START: state_next = EXP_WAIT;
            EXP_WAIT: begin
                if (!wait_first && ctl_mod_exp_finish) begin
                    capture_c  = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit_c) begin
                    expire_c   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus outputs decoded from the next state so they are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            wait_first         <= 1'b0;
            job_ready          <= 1'b1;
            busy               <= 1'b0;
            res_valid          <= 1'b0;
            ctl_reset_inverter <= 1'b0;
            ctl_reset_mod_exp  <= 1'b0;
        end else begin
            state              <= state_next;
            wait_first         <= (state == INV_START) || (state == EXP_START);
            job_ready          <= (state_next == IDLE);
            busy               <= (state_next != IDLE);
            res_valid          <= (state_next == DONE);
            ctl_reset_inverter <= (state_next == INV_START);
            ctl_reset_mod_exp  <= (state_next == EXP_START);
        end
    end

    // Operands held from one accepted job to the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_p    <= '0;
            ctl_q    <= '0;
            ctl_mode <= 1'b0;
            ctl_msg  <= '0;
        end else if (take_job_c) begin
            ctl_p    <= job_p;
            ctl_q    <= job_q;
            ctl_mode <= job_mode;
            ctl_msg  <= job_msg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_msg <= '0;
        end else if (capture_c) begin
            res_msg <= ctl_msg_out;
        end else if (expire_c) begin
            res_msg <= MSG_W'(0);
        end
    end

`ifdef RSA_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_timeout <= 1'b0;
        end else if (take_job_c || capture_c) begin
            res_timeout <= 1'b0;
        end else if (expire_c) begin
            res_timeout <= 1'b1;
        end
    end
`else
    assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Directed self-checking bench for rsa_job_sequencer with a hand-driven control-block stub.
// The timeout scenario runs only when RSA_SEQ_TIMEOUT_EN is defined.
module tb_rsa_job_sequencer;

    localparam int unsigned W = 128;
`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 65535;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           job_valid, job_ready, job_mode;
    logic [W-1:0]   job_p, job_q;
    logic [2*W-1:0] job_msg;
    logic           res_valid, res_ready, res_timeout;
    logic [2*W-1:0] res_msg;
    logic [W-1:0]   ctl_p, ctl_q;
    logic           ctl_mode;
    logic [2*W-1:0] ctl_msg, ctl_msg_out;
    logic           ctl_reset_inverter, ctl_reset_mod_exp;
    logic           ctl_inverter_finish, ctl_mod_exp_finish;
    logic           busy;

    int errors = 0;
    int checks = 0;

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_p(job_p), .job_q(job_q), .job_mode(job_mode), .job_msg(job_msg),
        .res_valid(res_valid), .res_ready(res_ready), .res_msg(res_msg), .res_timeout(res_timeout),
        .ctl_p(ctl_p), .ctl_q(ctl_q), .ctl_mode(ctl_mode), .ctl_msg(ctl_msg),
        .ctl_reset_inverter(ctl_reset_inverter), .ctl_reset_mod_exp(ctl_reset_mod_exp),
        .ctl_inverter_finish(ctl_inverter_finish), .ctl_mod_exp_finish(ctl_mod_exp_finish),
        .ctl_msg_out(ctl_msg_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Toy stand-in for the control block: XOR with the key is its own inverse.
    function automatic logic [2*W-1:0] toy(input logic [2*W-1:0] m, input logic [W-1:0] p, input logic [W-1:0] q);
        return m ^ {p, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic mode,
                          input logic [2*W-1:0] msg, input logic [2*W-1:0] expect_msg, input int stall);
        job_p = p; job_q = q; job_mode = mode; job_msg = msg; job_valid = 1'b1;
        res_ready = 1'b0;
        tick();
        job_valid = 1'b0;
        chk("inv_pulse", 256'(ctl_reset_inverter), 256'(1'b1));
        chk("ready_low", 256'(job_ready), 256'(1'b0));
        chk("busy_high", 256'(busy), 256'(1'b1));
        chk("ctl_p", 256'(ctl_p), 256'(p));
        chk("ctl_q", 256'(ctl_q), 256'(q));
        chk("ctl_mode", 256'(ctl_mode), 256'(mode));
        chk("ctl_msg", ctl_msg, msg);
        tick();
        chk("inv_pulse_end", 256'(ctl_reset_inverter), 256'(1'b0));
        ctl_inverter_finish = 1'b1;
        tick();
        chk("inv_blank", 256'(ctl_reset_mod_exp), 256'(1'b0));
        tick();
        chk("exp_pulse", 256'(ctl_reset_mod_exp), 256'(1'b1));
        tick();
        chk("exp_pulse_end", 256'(ctl_reset_mod_exp), 256'(1'b0));
        ctl_msg_out = toy(msg, p, q);
        ctl_mod_exp_finish = 1'b1;
        tick();
        chk("exp_blank", 256'(res_valid), 256'(1'b0));
        tick();
        ctl_mod_exp_finish = 1'b0;
        ctl_msg_out = '1;
        chk("res_valid", 256'(res_valid), 256'(1'b1));
        chk("res_msg", res_msg, expect_msg);
        chk("res_timeout", 256'(res_timeout), 256'(1'b0));
        for (int i = 0; i < stall; i++) begin
            job_valid = 1'b1;
            job_p = ~p;
            job_msg = ~msg;
            tick();
            chk("stall_valid", 256'(res_valid), 256'(1'b1));
            chk("stall_msg", res_msg, expect_msg);
            chk("stall_ready", 256'(job_ready), 256'(1'b0));
            chk("stall_no_capture", 256'(ctl_p), 256'(p));
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_drop", 256'(res_valid), 256'(1'b0));
        chk("back_idle", 256'(job_ready), 256'(1'b1));
        chk("idle_busy", 256'(busy), 256'(1'b0));
        chk("hold_ctl_msg", ctl_msg, msg);
    endtask

    logic [W-1:0]   p1, q1, p2, q2;
    logic [2*W-1:0] m1, m2, enc;

    initial begin
        p1 = 128'd8475698667747010771;
        q1 = 128'd11297384090418420749;
        m1 = 256'h95ebe2590000;
        p2 = 128'd113680897410347;
        q2 = 128'd7999808077935876437321;
        m2 = 256'h7b2800000000;

        reset = 1'b1;
        job_valid = 1'b0; job_p = '0; job_q = '0; job_mode = 1'b0; job_msg = '0;
        res_ready = 1'b0; ctl_msg_out = '0;
        ctl_inverter_finish = 1'b0; ctl_mod_exp_finish = 1'b0;
        tick();
        chk("rst_ready", 256'(job_ready), 256'(1'b1));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_valid", 256'(res_valid), 256'(1'b0));
        chk("rst_timeout", 256'(res_timeout), 256'(1'b0));
        chk("rst_inv", 256'(ctl_reset_inverter), 256'(1'b0));
        chk("rst_exp", 256'(ctl_reset_mod_exp), 256'(1'b0));
        chk("rst_res_msg", res_msg, 256'h0);
        chk("rst_ctl_p", 256'(ctl_p), 256'h0);
        reset = 1'b0;
        tick();

        // Basic encrypt job; inverter finish stays high afterwards as a stale level.
        do_job(p1, q1, 1'b0, m1, toy(m1, p1, q1), 0);

        // Encrypt then decrypt chain round-trips the message; also stalls DONE 20 cycles.
        enc = toy(m2, p2, q2);
        do_job(p2, q2, 1'b0, m2, enc, 0);
        do_job(p2, q2, 1'b1, enc, 256'h7b2800000000, 20);

        // Reset during EXP_WAIT abandons the job.
        job_p = p1; job_q = q1; job_mode = 1'b0; job_msg = m1; job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_busy", 256'(busy), 256'(1'b1));
        #2 reset = 1'b1;
        #1;
        chk("async_ready", 256'(job_ready), 256'(1'b1));
        chk("async_busy", 256'(busy), 256'(1'b0));
        chk("async_ctl_msg", ctl_msg, 256'h0);
        chk("async_ctl_q", 256'(ctl_q), 256'h0);
        tick();
        tick();
        chk("rst_no_result", 256'(res_valid), 256'(1'b0));
        reset = 1'b0;
        tick();
        chk("post_rst_valid", 256'(res_valid), 256'(1'b0));
        do_job(p1, q1, 1'b1, m2, toy(m2, p1, q1), 0);

`ifdef RSA_SEQ_TIMEOUT_EN
        ctl_inverter_finish = 1'b0;
        job_p = p1; job_q = q1; job_mode = 1'b0; job_msg = m1; job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", 256'(res_valid), 256'(1'b0));
        tick();
        chk("to_valid", 256'(res_valid), 256'(1'b1));
        chk("to_flag", 256'(res_timeout), 256'(1'b1));
        chk("to_msg", res_msg, 256'h0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("to_idle", 256'(job_ready), 256'(1'b1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
